// File: rtl/rv5stage_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : rv5stage_pkg
// Brief   : Shared widths and types for the 5-stage core writeback path.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package rv5stage_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  // Writeback source identifiers; also the encoding of the arbiter's history.
  typedef enum logic {
    WB_SRC_A = 1'b0,
    WB_SRC_B = 1'b1
  } wb_src_e;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : rr_arb2
// Brief   : Two-way round-robin arbiter, one-hot combinational grant with a
//           registered record of the last winner.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module rr_arb2
  import rv5stage_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    req_a,
  input  logic    req_b,
  output logic    gnt_a,
  output logic    gnt_b,
  output wb_src_e last_grant
);

  // A wins when alone or when B won the previous contested or lone grant.
  always_comb begin
    gnt_a = req_a && (!req_b || (last_grant == WB_SRC_B));
    gnt_b = req_b && !gnt_a;
  end

  // History updates on every grant; reset favours A on the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= WB_SRC_B;
    end else if (gnt_a) begin
      last_grant <= WB_SRC_A;
    end else if (gnt_b) begin
      last_grant <= WB_SRC_B;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_scoreboard.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : wb_scoreboard
// Brief   : Register scoreboard with RAW/WAW issue stall and round-robin
//           ALU/LSU writeback onto a single registered register-file port.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module wb_scoreboard
  import rv5stage_pkg::*;
#(
  parameter int XLEN = rv5stage_pkg::XLEN,
  parameter int AW   = rv5stage_pkg::REG_AW,
  parameter int NREG = 1 << AW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rs1,
  input  logic [AW-1:0]   iss_rs2,
  input  logic [AW-1:0]   iss_rd,
  input  logic            iss_rd_wen,
  output logic            iss_ready,
  input  logic            a_valid,
  input  logic [AW-1:0]   a_addr,
  input  logic [XLEN-1:0] a_data,
  output logic            a_ready,
  input  logic            b_valid,
  input  logic [AW-1:0]   b_addr,
  input  logic [XLEN-1:0] b_data,
  output logic            b_ready,
  output logic            w_enable,
  output logic [AW-1:0]   w_addr,
  output logic [XLEN-1:0] w_data,
  output logic [AW:0]     pending_cnt,
  output logic            wb_err
);

  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;
  logic [AW:0]     cnt_nxt;
  logic            set_en;
  logic            gnt_a;
  logic            gnt_b;
  logic            gnt_any;
  logic [AW-1:0]   gnt_addr;
  logic [XLEN-1:0] gnt_data;
  wb_src_e         last_grant;

  rr_arb2 u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_a      (a_valid),
    .req_b      (b_valid),
    .gnt_a      (gnt_a),
    .gnt_b      (gnt_b),
    .last_grant (last_grant)
  );

  // Hazard check against current state only; a commit this cycle is not bypassed.
  always_comb begin
    iss_ready = !(pending[iss_rs1] && (iss_rs1 != '0))
             && !(pending[iss_rs2] && (iss_rs2 != '0))
             && !(iss_rd_wen && (iss_rd != '0) && pending[iss_rd]);
    set_en    = iss_valid && iss_ready && iss_rd_wen && (iss_rd != '0);
  end

  // Route the winning requester onto the write-port input.
  always_comb begin
    a_ready  = gnt_a;
    b_ready  = gnt_b;
    gnt_any  = gnt_a || gnt_b;
    gnt_addr = gnt_a ? a_addr : b_addr;
    gnt_data = gnt_a ? a_data : b_data;
  end

  // Next pending set: commit clears first so a same-index issue set wins.
  always_comb begin
    pending_nxt = pending;
    if (w_enable) begin
      pending_nxt[w_addr] = 1'b0;
    end
    if (set_en) begin
      pending_nxt[iss_rd] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
    cnt_nxt = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt_nxt = cnt_nxt + (AW+1)'(pending_nxt[i]);
    end
  end

  // Scoreboard state and its population count move together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= '0;
      pending_cnt <= '0;
    end else begin
      pending     <= pending_nxt;
      pending_cnt <= cnt_nxt;
    end
  end

  // Registered write port; a grant to x0 is consumed without writing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_enable <= 1'b0;
      w_addr   <= '0;
      w_data   <= '0;
    end else begin
      w_enable <= gnt_any && (gnt_addr != '0);
      if (gnt_any) begin
        w_addr <= gnt_addr;
        w_data <= gnt_data;
      end
    end
  end

  // Sticky flag for a writeback that no issued instruction is waiting on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_err <= 1'b0;
    end else if (gnt_any && (gnt_addr != '0) && !pending[gnt_addr]) begin
      wb_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_scoreboard.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_wb_scoreboard
// Brief   : Self-checking bench for wb_scoreboard.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_wb_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iss_valid;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd;
  logic        iss_rd_wen;
  logic        iss_ready;
  logic        a_valid, b_valid;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic        w_enable;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic [5:0]  pending_cnt;
  logic        wb_err;

  wb_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_rd(iss_rd), .iss_rd_wen(iss_rd_wen), .iss_ready(iss_ready),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .w_enable(w_enable), .w_addr(w_addr), .w_data(w_data),
    .pending_cnt(pending_cnt), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       wen;
    logic       exp_ready;
  } hz_t;

  wr_t         exp_q[$];
  logic [31:0] mpend;
  logic        mlast;   // 1 = B won last
  logic        merr;
  int          cycle;
  int          errors;
  int          checks;
  logic        g_a, g_b;
  logic        s_iss_ready, s_a_ready, s_b_ready, s_w_enable, s_wb_err;
  logic [4:0]  s_w_addr;
  logic [31:0] s_w_data;
  logic [5:0]  s_cnt;
  hz_t         tab[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", nm, cycle, act, exp);
    end
  endtask

  function automatic logic model_ready(input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [4:0] rd, input logic wen);
    logic r;
    r = 1'b1;
    if (rs1 != 0 && mpend[rs1]) r = 1'b0;
    if (rs2 != 0 && mpend[rs2]) r = 1'b0;
    if (wen && rd != 0 && mpend[rd]) r = 1'b0;
    return r;
  endfunction

  task automatic set_iss(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic wen);
    iss_valid = v; iss_rs1 = rs1; iss_rs2 = rs2; iss_rd = rd; iss_rd_wen = wen;
  endtask

  task automatic model_reset();
    mpend = '0;
    mlast = 1'b1;
    merr  = 1'b0;
    exp_q.delete();
  endtask

  // One clock cycle: inputs already driven at posedge+1; check mid-cycle, then
  // advance the reference model at the edge.
  task automatic cyc();
    logic        ga, gb, mr, clr;
    logic [4:0]  ca, gaddr;
    logic [31:0] gdata;
    wr_t         e;
    #4;
    mr = model_ready(iss_rs1, iss_rs2, iss_rd, iss_rd_wen);
    ga = a_valid && (!b_valid || mlast);
    gb = b_valid && !ga;
    chk("iss_ready", iss_ready, mr);
    chk("a_ready", a_ready, ga);
    chk("b_ready", b_ready, gb);
    clr = 1'b0;
    ca  = '0;
    if (exp_q.size() > 0 && exp_q[0].cyc == cycle) begin
      chk("w_enable", w_enable, 1);
      chk("w_addr", w_addr, exp_q[0].addr);
      chk("w_data", w_data, exp_q[0].data);
      clr = 1'b1;
      ca  = exp_q[0].addr;
      void'(exp_q.pop_front());
    end else begin
      chk("w_enable_idle", w_enable, 0);
    end
    chk("pending_cnt", pending_cnt, $countones(mpend));
    chk("wb_err", wb_err, merr);
    s_iss_ready = iss_ready; s_a_ready = a_ready; s_b_ready = b_ready;
    s_w_enable = w_enable; s_w_addr = w_addr; s_w_data = w_data;
    s_cnt = pending_cnt; s_wb_err = wb_err;
    g_a = ga; g_b = gb;
    gaddr = ga ? a_addr : b_addr;
    gdata = ga ? a_data : b_data;
    @(posedge clk);
    if (ga || gb) begin
      if (gaddr != 0) begin
        if (!mpend[gaddr]) merr = 1'b1;
        e.cyc = cycle + 1; e.addr = gaddr; e.data = gdata;
        exp_q.push_back(e);
      end
      mlast = gb;
    end
    if (clr) mpend[ca] = 1'b0;
    if (iss_valid && mr && iss_rd_wen && iss_rd != 0) mpend[iss_rd] = 1'b1;
    mpend[0] = 1'b0;
    cycle++;
    #1;
  endtask

  initial begin
    errors = 0; checks = 0; cycle = 0;
    tab[0] = '{5'd5,  5'd0,  5'd0,  1'b0, 1'b0};
    tab[1] = '{5'd0,  5'd5,  5'd0,  1'b0, 1'b0};
    tab[2] = '{5'd1,  5'd2,  5'd3,  1'b1, 1'b1};
    tab[3] = '{5'd0,  5'd0,  5'd10, 1'b1, 1'b0};
    tab[4] = '{5'd0,  5'd0,  5'd10, 1'b0, 1'b1};
    tab[5] = '{5'd10, 5'd10, 5'd1,  1'b1, 1'b0};
    tab[6] = '{5'd0,  5'd0,  5'd0,  1'b1, 1'b1};
    tab[7] = '{5'd31, 5'd1,  5'd31, 1'b1, 1'b1};

    rst_n = 1'b0;
    set_iss(0, 0, 0, 0, 0);
    a_valid = 0; a_addr = 0; a_data = 0;
    b_valid = 0; b_addr = 0; b_data = 0;
    model_reset();
    #2;
    chk("rst_w_enable", w_enable, 0);
    chk("rst_pending_cnt", pending_cnt, 0);
    chk("rst_wb_err", wb_err, 0);
    chk("rst_iss_ready", iss_ready, 1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Idle: any registers are free.
    set_iss(0, 5'd7, 5'd31, 5'd12, 1); cyc();
    set_iss(0, 0, 0, 0, 0); cyc();

    // Contention: A wins the first tie after reset, B next cycle.
    set_iss(1, 0, 0, 5'd3, 1); cyc();
    set_iss(1, 0, 0, 5'd7, 1); cyc();
    set_iss(0, 0, 0, 0, 0);
    a_valid = 1; a_addr = 5'd3; a_data = 32'h1111_0003;
    b_valid = 1; b_addr = 5'd7; b_data = 32'h2222_0007;
    for (int k = 0; k < 4 && (a_valid || b_valid); k++) begin
      cyc();
      if (k == 0) begin
        chk("arb_first_a", s_a_ready, 1);
        chk("arb_first_b", s_b_ready, 0);
      end
      if (k == 1) chk("arb_second_b", s_b_ready, 1);
      if (g_a) a_valid = 0;
      if (g_b) b_valid = 0;
    end
    chk("arb_drained", {a_valid, b_valid}, 2'b00);
    cyc(); cyc();
    chk("arb_cnt_zero", s_cnt, 0);

    // Producer x5 and a held dependent: grant c3, write c4, ready c5.
    set_iss(1, 0, 0, 5'd5, 1); cyc();
    set_iss(1, 5'd5, 0, 0, 0); cyc();
    chk("raw_stall_c1", s_iss_ready, 0);
    cyc();
    chk("raw_stall_c2", s_iss_ready, 0);
    a_valid = 1; a_addr = 5'd5; a_data = 32'hDEAD_BEEF; cyc();
    chk("raw_grant_c3", s_a_ready, 1);
    chk("raw_stall_c3", s_iss_ready, 0);
    a_valid = 0; cyc();
    chk("raw_wen_c4", s_w_enable, 1);
    chk("raw_wdata_c4", s_w_data, 32'hDEAD_BEEF);
    chk("raw_stall_c4", s_iss_ready, 0);
    chk("raw_cnt_c4", s_cnt, 1);
    cyc();
    chk("raw_ready_c5", s_iss_ready, 1);
    chk("raw_cnt_c5", s_cnt, 0);
    set_iss(0, 0, 0, 0, 0);

    // WAW: second write of x4 waits for the first to commit.
    set_iss(1, 0, 0, 5'd4, 1); cyc();
    cyc();
    chk("waw_stall_c1", s_iss_ready, 0);
    a_valid = 1; a_addr = 5'd4; a_data = 32'h0000_0044; cyc();
    a_valid = 0; cyc();
    chk("waw_stall_c3", s_iss_ready, 0);
    cyc();
    chk("waw_fire_c4", s_iss_ready, 1);
    chk("waw_cnt_c4", s_cnt, 0);
    set_iss(0, 0, 0, 0, 0);
    b_valid = 1; b_addr = 5'd4; b_data = 32'h0000_0444; cyc();
    chk("waw_cnt_c5", s_cnt, 1);
    b_valid = 0; cyc(); cyc();

    // Hazard table against pending {x5, x10}.
    set_iss(1, 0, 0, 5'd5, 1); cyc();
    set_iss(1, 0, 0, 5'd10, 1); cyc();
    for (int i = 0; i < 8; i++) begin
      set_iss(0, tab[i].rs1, tab[i].rs2, tab[i].rd, tab[i].wen);
      cyc();
      chk("hz_tab", s_iss_ready, tab[i].exp_ready);
    end
    set_iss(0, 0, 0, 0, 0);
    a_valid = 1; a_addr = 5'd5;  a_data = 32'hA5A5_0005;
    b_valid = 1; b_addr = 5'd10; b_data = 32'h5A5A_000A;
    for (int k = 0; k < 4 && (a_valid || b_valid); k++) begin
      cyc();
      if (g_a) a_valid = 0;
      if (g_b) b_valid = 0;
    end
    chk("hz_drained", {a_valid, b_valid}, 2'b00);
    cyc(); cyc();

    // Stray writeback sets the sticky error; x0 write is consumed silently.
    b_valid = 1; b_addr = 5'd9; b_data = 32'h0000_0099; cyc();
    chk("err_grant_b", s_b_ready, 1);
    b_valid = 0; cyc();
    chk("err_set", s_wb_err, 1);
    a_valid = 1; a_addr = 5'd0; a_data = 32'hFFFF_FFFF; cyc();
    chk("x0_grant", s_a_ready, 1);
    a_valid = 0; cyc();
    chk("x0_no_write", s_w_enable, 0);
    chk("x0_cnt", s_cnt, 0);
    chk("err_sticky", s_wb_err, 1);

    // Reset while a grant is in flight.
    set_iss(1, 0, 0, 5'd2, 1); cyc();
    set_iss(1, 0, 0, 5'd6, 1); cyc();
    set_iss(0, 0, 0, 0, 0);
    a_valid = 1; a_addr = 5'd2; a_data = 32'h0000_0222; cyc();
    a_valid = 0;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_w_enable", w_enable, 0);
    chk("mid_rst_w_addr", w_addr, 0);
    chk("mid_rst_w_data", w_data, 0);
    chk("mid_rst_cnt", pending_cnt, 0);
    chk("mid_rst_wb_err", wb_err, 0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    set_iss(0, 5'd2, 5'd6, 0, 0); cyc();
    chk("post_rst_ready", s_iss_ready, 1);
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
